// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_pkg
//  Description : Shared definitions for the Hack ROM loader. This package
//                holds the loader state encoding, the word and address
//                widths, and a helper that identifies the byte-receiving
//                states.
//  Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int HACK_ADDR_W = 15;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_SUM_HI  = 4'd5,
    ST_SUM_LO  = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } loader_state_t;

  // The LEN, DATA and SUM states are the only states that consume bytes.
  function automatic logic is_receiving(input loader_state_t s);
    return (s == ST_LEN_HI)  || (s == ST_LEN_LO)  ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
           (s == ST_SUM_HI)  || (s == ST_SUM_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : hack_rom_loader
//  Description : Receives a big-endian program image as a byte stream
//                (16-bit length N, then N words, plus an optional 16-bit
//                checksum) and writes it word by word into the instruction
//                ROM. The CPU is held in reset until the image is complete.
//  Revision    : 1.0 - initial release
//
//  Configuration macro:
//    HACK_ROM_LOADER_CHECKSUM_EN - when defined, a 16-bit checksum trailer
//    follows the data. It is compared against the mod-2^16 sum of all data
//    words, and a mismatch ends the load in ERR.
//
//  Ports:
//    clk        in   system clock
//    reset      in   asynchronous, active-low reset
//    start      in   one-cycle pulse that begins a load (ignored while busy)
//    rx_valid   in   byte available on rx_data
//    rx_data    in   incoming byte
//    rx_ready   out  loader accepts a byte this cycle
//    rom_we     out  one-cycle ROM write strobe
//    rom_addr   out  ROM word address (word index 0..N-1)
//    rom_wdata  out  ROM write data
//    cpu_reset  out  active-high CPU reset, low only in DONE
//    busy       out  load in progress
//    done       out  image loaded, sticky until the next start
//    err        out  load failed, sticky until the next start
// ============================================================================
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W    = HACK_ADDR_W,
  parameter int MAX_WORDS = 32768
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   rom_we,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [HACK_WORD_W-1:0] rom_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

  // The state that follows the data phase (or a zero-length image).
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  localparam loader_state_t c_after_data = ST_SUM_HI;
`else
  localparam loader_state_t c_after_data = ST_DONE;
`endif

  loader_state_t          r_state;
  loader_state_t          w_state_nxt;
  logic [7:0]             r_hold;   // high byte of the field being assembled
  logic [HACK_WORD_W-1:0] r_len;
  logic [HACK_WORD_W-1:0] r_count;  // index of the next word to write
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  logic [HACK_WORD_W-1:0] r_sum;
`endif

  logic                   w_xfer;
  logic                   w_start_load;
  logic [HACK_WORD_W-1:0] w_word;
  logic                   w_last;

  always_comb begin
    w_xfer       = rx_valid && is_receiving(r_state);
    w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                             (r_state == ST_ERR));
    w_word       = {r_hold, rx_data};
    // r_len is nonzero whenever the DATA states are reached.
    w_last       = (r_count == (r_len - 16'd1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) w_state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_xfer) begin
          if ({1'b0, w_word} > c_max_words) w_state_nxt = ST_ERR;
          else if (w_word == 16'd0)         w_state_nxt = c_after_data;
          else                              w_state_nxt = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (w_xfer) w_state_nxt = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        if (w_xfer) w_state_nxt = w_last ? c_after_data : ST_DATA_HI;
      end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      ST_SUM_HI: begin
        if (w_xfer) w_state_nxt = ST_SUM_LO;
      end
      ST_SUM_LO: begin
        if (w_xfer) w_state_nxt = (w_word == r_sum) ? ST_DONE : ST_ERR;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and all outputs are registered. The status outputs are decoded
  // from the next state, so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_len     <= '0;
      r_count   <= '0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      rx_ready  <= is_receiving(w_state_nxt);
      busy      <= is_receiving(w_state_nxt);
      cpu_reset <= (w_state_nxt != ST_DONE);
      done      <= (w_state_nxt == ST_DONE);
      err       <= (w_state_nxt == ST_ERR);
      rom_we    <= 1'b0;

      if (w_start_load) begin
        r_count <= '0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        r_sum   <= '0;
`endif
      end

      if (w_xfer) begin
        case (r_state)
          ST_LEN_HI, ST_DATA_HI, ST_SUM_HI: r_hold <= rx_data;
          ST_LEN_LO:                        r_len  <= w_word;
          ST_DATA_LO: begin
            rom_we    <= 1'b1;
            rom_addr  <= r_count[ADDR_W-1:0];
            rom_wdata <= w_word;
            r_count   <= r_count + 16'd1;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            r_sum     <= r_sum + w_word;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hack_rom_loader
//  Description : Scoreboard bench for hack_rom_loader. The load tasks build
//                byte streams from word images and push the expected ROM
//                writes into a queue. A monitor pops an entry for each
//                rom_we cycle and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_rom_loader;

  localparam int MAXW = 32768;

  typedef struct packed {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] img[$];

  hack_rom_loader #(.ADDR_W(15), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: each write strobe must match the oldest outstanding write.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(rom_addr), 32'h7fff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(rom_addr), 32'(mon_e.a));
        chk("write_data", 32'(rom_wdata), 32'(mon_e.d));
      end
    end
    // The CPU is released exactly when the image is reported complete.
    chk("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
    chk("start_done_err", 32'({done, err}), 32'd0);
  endtask

  // Load img with header length n_len. The gap before each byte after the
  // first is random in [gmin, gmax].
  task automatic run_load(input int n_len, input int gmin, input int gmax,
                          input bit corrupt, input bit mid_start);
    logic [7:0]  bs[$];
    logic [15:0] sum = 16'd0;
    bit          ok;
    int          g;
    bs.push_back(8'(n_len >> 8));
    bs.push_back(8'(n_len));
    if (n_len > MAXW) begin
      ok = 1'b0;
    end else begin
      for (int i = 0; i < n_len; i++) begin
        bs.push_back(img[i][15:8]);
        bs.push_back(img[i][7:0]);
        exp_q.push_back('{a: 15'(i), d: img[i]});
        sum = sum + img[i];
      end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      sum = sum + 16'(corrupt);
      bs.push_back(sum[15:8]);
      bs.push_back(sum[7:0]);
      ok = !corrupt;
`else
      ok = 1'b1;
`endif
    end
    do_start();
    for (int i = 0; i < bs.size(); i++) begin
      if (i > 0) begin
        g = $urandom_range(gmax, gmin);
        repeat (g) @(negedge clk);
      end
      if (mid_start && i == 3) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_start_busy", 32'(busy), 32'd1);
      end
      send_byte(bs[i]);
    end
    chk("end_done", 32'(done), 32'(ok));
    chk("end_err", 32'(err), 32'(!ok));
    chk("end_cpu_reset", 32'(cpu_reset), 32'(!ok));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_rom_we"}, 32'(rom_we), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_rom_wdata"}, 32'(rom_wdata), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    // Two words at full rate, then the same image with 3-cycle gaps.
    img = '{16'h1234, 16'hABCD};
    run_load(2, 0, 0, 1'b0, 1'b0);
    img = '{16'h1234, 16'hABCD};
    run_load(2, 3, 3, 1'b0, 1'b0);

    // Zero length, oversize lengths, and the checksum vectors.
    img.delete();
    run_load(0, 0, 0, 1'b0, 1'b0);
    run_load(32769, 0, 0, 1'b0, 1'b0);
    run_load(65535, 1, 2, 1'b0, 1'b0);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    img = '{16'h0005};
    run_load(1, 0, 0, 1'b1, 1'b0);
    img = '{16'h0005};
    run_load(1, 0, 0, 1'b0, 1'b0);
`endif

    // A start pulse in the middle of a load must be ignored.
    img = '{16'h0001, 16'hFFFF, 16'h8000};
    run_load(3, 0, 1, 1'b0, 1'b1);

    // Randomized images, gaps and checksum corruption.
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(8, 1);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(16'($urandom));
      run_load(len, 0, $urandom_range(3, 0), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)));
    end

    // Reset in the middle of a load abandons the partial image.
    img.delete();
    for (int i = 0; i < 4; i++) begin
      img.push_back(16'($urandom));
      exp_q.push_back('{a: 15'(i), d: img[i]});
    end
    do_start();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 2; i++) begin
      send_byte(img[i][15:8]);
      send_byte(img[i][7:0]);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("abandoned_writes", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    img = '{16'h7FFF, 16'h0042};
    run_load(2, 0, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
